mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage data port of the pipelined RISC-V core.
- Arbitrates between the two ports, sequences each memory transaction and returns read data with a one-cycle valid pulse.
- Drives the pipeline-wide stall that freezes the pipeline registers while any access is outstanding.
- Includes a timeout watchdog against a hung memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be a multiple of 8.
- MAX_WAIT, 15, BUSY cycles without mem_ack before timeout (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high until dm_valid.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  DATA_W/8  byte enables.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- stall  out  1  pipeline freeze.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wait_cnt=0; last_grant=FETCH.
  - Outputs cleared: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata, if_valid, dm_valid and err all 0.
  - Reset mid-transaction abandons it; no valid pulse is produced.
- FSM states: IDLE, BUSY_F, BUSY_D, RESP. All registered.
- IDLE:
  - Only dm_req: next state BUSY_D.
  - Only if_req: next state BUSY_F.
  - Both requesting: grant the port opposite to last_grant (round-robin), so data wins the first conflict after reset.
  - On grant: latch the port's addr/wdata/be/we into the mem_* registers, set last_grant, clear wait_cnt.
  - Fetch grant forces mem_we=0.
  - mem_ack while in IDLE or RESP is ignored.
- BUSY_F / BUSY_D:
  - mem_req=1; mem_* outputs stable for the whole state.
  - mem_ack=1 at an edge: capture mem_rdata into the granted port's rdata register, go to RESP.
  - No ack: wait_cnt increments. When wait_cnt reaches MAX_WAIT-1 with no ack, the access times out: rdata register <= 0, err <= 1, go to RESP.
- RESP:
  - mem_req=0, mem_we=0.
  - Exactly one of if_valid/dm_valid is high for this single cycle.
  - Next state IDLE.
  - The requester drops its req at the end of this cycle, so IDLE never re-grants a completed request.
- Latency: req seen in IDLE at cycle 0 -> mem_req cycles 1..N -> valid in cycle N+1 -> IDLE in cycle N+2. Minimum 3-cycle turnaround.
- rdata registers hold their value until the next completion on that port.
- stall (combinational) = (if_req & ~if_valid) | (dm_req & ~dm_valid).
- err is sticky; it is cleared only by reset.
- wait_cnt width: ceil(log2(MAX_WAIT+1)).

Test Plan:
- Reset mid-access: assert rst=0 during BUSY_D -> all outputs 0 immediately; a later mem_ack produces no valid pulse; state is IDLE on release.
- Single fetch:
  - Stimulus: if_req, if_addr=0x00000040; mem_ack on the 2nd BUSY cycle with mem_rdata=0x00500093.
  - Required: mem_addr=0x40 and mem_we=0 during BUSY; if_valid pulses in cycle 3 with if_rdata=0x00500093; stall high cycles 0-2, low in cycle 3.
- Simultaneous requests after reset:
  - Stimulus: if_req plus dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=0xF.
  - Required: store granted first (mem_we=1, mem_be=0xF); fetch granted after RESP with mem_we=0.
- Sustained contention: both reqs reasserted immediately after every valid pulse -> grant sequence D,F,D,F; no port is granted twice in a row.
- Timeout: MAX_WAIT=4, dm load with no mem_ack -> 4 BUSY cycles, then dm_valid=1 with dm_rdata=0; err=1 and stays 1 through later successful accesses.
- Stray ack: mem_ack=1 while in IDLE -> no valid pulse, no state change, rdata registers unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and data ports,
// with registered completion pulses, a pipeline stall and a sticky timeout watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall,
    output logic                err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D, RESP} state_t;
    typedef enum logic {FETCH, DATA} port_t;

    state_t             state;
    port_t              last_grant;
    logic [CNT_W-1:0]   wait_cnt;

    assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= FETCH;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Data wins a conflict unless it was the last port served.
                    if (dm_req && (!if_req || last_grant == FETCH)) begin
                        mem_req    <= 1'b1;
                        mem_we     <= dm_we;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        mem_be     <= dm_be;
                        last_grant <= DATA;
                        wait_cnt   <= '0;
                        state      <= BUSY_D;
                    end else if (if_req) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_be     <= '1;
                        last_grant <= FETCH;
                        wait_cnt   <= '0;
                        state      <= BUSY_F;
                    end
                end
                BUSY_F, BUSY_D: begin
                    if (mem_ack || wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        // A timed-out access completes with zero data and raises err.
                        if (state == BUSY_F) begin
                            if_rdata <= mem_ack ? mem_rdata : '0;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= mem_ack ? mem_rdata : '0;
                            dm_valid <= 1'b1;
                        end
                        if (!mem_ack) err <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever a valid pulse appears.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall;
    logic        err;

    int checks = 0;
    int failures = 0;
    int ack_lat = 0;
    int busy_n = 0;
    bit stray_ack = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: acks on the ack_lat-th BUSY cycle (never when ack_lat is 0).
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            busy_n++;
            mem_ack   = (ack_lat != 0 && busy_n == ack_lat);
            mem_rdata = memval(mem_addr);
        end else begin
            busy_n    = 0;
            mem_ack   = stray_ack;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    // Monitor: every completion pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (if_valid || dm_valid) begin
            exp_t e;
            chk("one_valid_at_a_time", {62'b0, if_valid, dm_valid} == 64'd3, 64'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got if_valid=%0b dm_valid=%0b required none", if_valid, dm_valid);
            end else begin
                e = sb.pop_front();
                chk("sb_port", {63'b0, dm_valid}, {63'b0, e.is_d});
                chk("sb_rdata", e.is_d ? dm_rdata : if_rdata, e.data);
                chk("sb_err", err, e.err);
            end
        end
    end

    task automatic req_port(input bit is_d, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input bit drop);
        int n;
        if (is_d) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? dm_valid : if_valid) && n < 40);
        if (n >= 40) chk("req_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (drop) begin
            if (is_d) begin dm_req = 1'b0; dm_we = 1'b0; end
            else if_req = 1'b0;
        end
    endtask

    initial begin
        int nb;
        // Reset state, asynchronously before any clock edge
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valids", {if_valid, dm_valid}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        chk("rst_err", err, 0);
        @(negedge clk); @(negedge clk); rst = 1'b1;

        // Reset mid-access during BUSY_D
        ack_lat = 0;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h1234_5678; dm_be = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_req", mem_req, 1);
        chk("mid_busy_addr", mem_addr, 32'h200);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", {mem_req, mem_we}, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_be", mem_be, 0);
        dm_req = 1'b0; dm_we = 1'b0; stray_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {mem_req, if_valid, dm_valid}, 0);
        end
        stray_ack = 1'b0;
        @(negedge clk);

        // Single fetch, ack on 2nd BUSY cycle
        ack_lat = 2;
        sb.push_back('{is_d: 0, data: 32'h0050_0093, err: 0});
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk("f_c0_stall", stall, 1);
        chk("f_c0_req", mem_req, 0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("f_busy_req", mem_req, 1);
            chk("f_busy_addr", mem_addr, 32'h40);
            chk("f_busy_we", mem_we, 0);
            chk("f_busy_stall", stall, 1);
        end
        @(negedge clk);
        chk("f_c3_valid", if_valid, 1);
        chk("f_c3_rdata", if_rdata, 32'h0050_0093);
        chk("f_c3_stall", stall, 0);
        chk("f_c3_mem_req", mem_req, 0);
        chk("f_err", err, 0);
        @(posedge clk); #1; if_req = 1'b0;

        // Simultaneous requests after reset: data store first
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        ack_lat = 1;
        sb.push_back('{is_d: 1, data: memval(32'h100), err: 0});
        sb.push_back('{is_d: 0, data: memval(32'h44), err: 0});
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        @(negedge clk);
        chk("s_c0_stall", stall, 1);
        @(negedge clk);
        chk("s_c1_req_we", {mem_req, mem_we}, 2'b11);
        chk("s_c1_be", mem_be, 4'hF);
        chk("s_c1_addr", mem_addr, 32'h100);
        chk("s_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("s_c2_dm_valid", dm_valid, 1);
        @(posedge clk); #1; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        chk("s_c3_idle", mem_req, 0);
        chk("s_c3_stall", stall, 1);
        @(negedge clk);
        chk("s_c4_req_we", {mem_req, mem_we}, 2'b10);
        chk("s_c4_addr", mem_addr, 32'h44);
        @(negedge clk);
        chk("s_c5_if_valid", if_valid, 1);
        @(posedge clk); #1; if_req = 1'b0;

        // Sustained contention: expect D,F,D,F
        ack_lat = 1;
        sb.push_back('{is_d: 1, data: memval(32'h300), err: 0});
        sb.push_back('{is_d: 0, data: memval(32'h80), err: 0});
        sb.push_back('{is_d: 1, data: memval(32'h304), err: 0});
        sb.push_back('{is_d: 0, data: memval(32'h84), err: 0});
        @(posedge clk); #1;
        fork
            begin
                req_port(1, 0, 32'h300, 0, 4'hF, 0);
                req_port(1, 0, 32'h304, 0, 4'hF, 1);
            end
            begin
                req_port(0, 0, 32'h80, 0, 4'h0, 0);
                req_port(0, 0, 32'h84, 0, 4'h0, 1);
            end
        join

        // Timeout: 4 BUSY cycles, zero data, sticky err
        ack_lat = 0;
        sb.push_back('{is_d: 1, data: 32'h0, err: 1});
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_be = 4'hF;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) nb++;
            if (dm_valid) break;
        end
        chk("to_busy_cycles", nb, 4);
        chk("to_valid", dm_valid, 1);
        chk("to_err", err, 1);
        @(posedge clk); #1; dm_req = 1'b0;

        // Successful access after timeout keeps err set
        ack_lat = 1;
        sb.push_back('{is_d: 0, data: memval(32'h48), err: 1});
        @(posedge clk); #1;
        req_port(0, 0, 32'h48, 0, 4'h0, 1);
        @(negedge clk);
        chk("err_sticky", err, 1);

        // Stray ack in IDLE
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_activity", {mem_req, if_valid, dm_valid}, 0);
            chk("stray_if_rdata", if_rdata, memval(32'h48));
            chk("stray_dm_rdata", dm_rdata, 0);
        end
        stray_ack = 1'b0;
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
